// File: rtl/riscv_wb_arbiter_if.sv
// riscv_wb_arbiter_if: writeback sources, hazard-check lookups and register-file write port
interface riscv_wb_arbiter_if #(parameter int XLEN = 64);
   logic            i_riscv_wb_pipe_regwrite;
   logic [4:0]      i_riscv_wb_pipe_rdaddr;
   logic [XLEN-1:0] i_riscv_wb_pipe_rddata;
   logic            i_riscv_wb_div_valid;
   logic [4:0]      i_riscv_wb_div_rdaddr;
   logic [XLEN-1:0] i_riscv_wb_div_rddata;
   logic            o_riscv_wb_div_ready;
   logic [4:0]      i_riscv_wb_chk_rs1addr;
   logic [4:0]      i_riscv_wb_chk_rs2addr;
   logic            o_riscv_wb_rs1_busy;
   logic            o_riscv_wb_rs2_busy;
   logic            o_riscv_wb_regwrite;
   logic [4:0]      o_riscv_wb_rdaddr;
   logic [XLEN-1:0] o_riscv_wb_rddata;

   modport slave (
      input  i_riscv_wb_pipe_regwrite, i_riscv_wb_pipe_rdaddr, i_riscv_wb_pipe_rddata,
      input  i_riscv_wb_div_valid, i_riscv_wb_div_rdaddr, i_riscv_wb_div_rddata,
      input  i_riscv_wb_chk_rs1addr, i_riscv_wb_chk_rs2addr,
      output o_riscv_wb_div_ready, o_riscv_wb_rs1_busy, o_riscv_wb_rs2_busy,
      output o_riscv_wb_regwrite, o_riscv_wb_rdaddr, o_riscv_wb_rddata
   );

   modport master (
      output i_riscv_wb_pipe_regwrite, i_riscv_wb_pipe_rdaddr, i_riscv_wb_pipe_rddata,
      output i_riscv_wb_div_valid, i_riscv_wb_div_rdaddr, i_riscv_wb_div_rddata,
      output i_riscv_wb_chk_rs1addr, i_riscv_wb_chk_rs2addr,
      input  o_riscv_wb_div_ready, o_riscv_wb_rs1_busy, o_riscv_wb_rs2_busy,
      input  o_riscv_wb_regwrite, o_riscv_wb_rdaddr, o_riscv_wb_rddata
   );
endinterface

// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter: merges pipeline writeback and queued divider results onto the register-file write port
module riscv_wb_arbiter #(
   parameter int XLEN       = 64,
   parameter int FIFO_DEPTH = 2
) (
   input logic               i_riscv_wb_clk,
   input logic               i_riscv_rf_rst,
   riscv_wb_arbiter_if.slave wb
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH = FIFO_DEPTH[PW:0];

   logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PW:0]     count_q, count_d;
   logic [FIFO_DEPTH-1:0] vld_q, vld_d;
   logic [4:0]      addr_q [FIFO_DEPTH];
   logic [4:0]      addr_d [FIFO_DEPTH];
   logic [XLEN-1:0] data_q [FIFO_DEPTH];
   logic [XLEN-1:0] data_d [FIFO_DEPTH];
   logic            regwrite_q, regwrite_d;
   logic [4:0]      rdaddr_q, rdaddr_d;
   logic [XLEN-1:0] rddata_q, rddata_d;
   logic            div_ready, pipe_act, div_xfer, div_live, pop, head_live, bypass, push;
   logic            rs1_hit, rs2_hit;

   assign div_ready                = (count_q < DEPTH);
   assign wb.o_riscv_wb_div_ready  = div_ready;
   assign wb.o_riscv_wb_regwrite   = regwrite_q;
   assign wb.o_riscv_wb_rdaddr     = rdaddr_q;
   assign wb.o_riscv_wb_rddata     = rddata_q;
   assign wb.o_riscv_wb_rs1_busy   = rs1_hit && (wb.i_riscv_wb_chk_rs1addr != 5'd0);
   assign wb.o_riscv_wb_rs2_busy   = rs2_hit && (wb.i_riscv_wb_chk_rs2addr != 5'd0);

   // Pick the winning source, then update queue occupancy, WAW kills and pointers
   always_comb begin
      pipe_act   = wb.i_riscv_wb_pipe_regwrite && (wb.i_riscv_wb_pipe_rdaddr != 5'd0);
      div_xfer   = wb.i_riscv_wb_div_valid && div_ready;
      div_live   = div_xfer && (wb.i_riscv_wb_div_rdaddr != 5'd0);
      pop        = !pipe_act && (count_q != '0);
      head_live  = pop && vld_q[rd_ptr_q];
      bypass     = !pipe_act && (count_q == '0) && div_live;
      push       = div_live && !bypass && !(pipe_act && (wb.i_riscv_wb_div_rdaddr == wb.i_riscv_wb_pipe_rdaddr));
      regwrite_d = pipe_act || head_live || bypass;
      rdaddr_d   = pipe_act  ? wb.i_riscv_wb_pipe_rdaddr :
                   head_live ? addr_q[rd_ptr_q] :
                   bypass    ? wb.i_riscv_wb_div_rdaddr : rdaddr_q;
      rddata_d   = pipe_act  ? wb.i_riscv_wb_pipe_rddata :
                   head_live ? data_q[rd_ptr_q] :
                   bypass    ? wb.i_riscv_wb_div_rddata : rddata_q;
      vld_d      = vld_q;
      addr_d     = addr_q;
      data_d     = data_q;
      if (pop) vld_d[rd_ptr_q] = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
         if (pipe_act && (addr_q[i] == wb.i_riscv_wb_pipe_rdaddr)) vld_d[i] = 1'b0;
      if (push) begin
         vld_d[wr_ptr_q]  = 1'b1;
         addr_d[wr_ptr_q] = wb.i_riscv_wb_div_rdaddr;
         data_d[wr_ptr_q] = wb.i_riscv_wb_div_rddata;
      end
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
   end

   // RAW hazard lookup against still-valid queued destinations
   always_comb begin
      rs1_hit = 1'b0;
      rs2_hit = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         rs1_hit = rs1_hit | (vld_q[i] && (addr_q[i] == wb.i_riscv_wb_chk_rs1addr));
         rs2_hit = rs2_hit | (vld_q[i] && (addr_q[i] == wb.i_riscv_wb_chk_rs2addr));
      end
   end

   // State and output registers; reset drops every queued result
   always_ff @(posedge i_riscv_wb_clk or posedge i_riscv_rf_rst) begin
      if (i_riscv_rf_rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         vld_q      <= '0;
         regwrite_q <= 1'b0;
         rdaddr_q   <= '0;
         rddata_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         vld_q      <= vld_d;
         regwrite_q <= regwrite_d;
         rdaddr_q   <= rdaddr_d;
         rddata_q   <= rddata_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
      end
   end
endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// tb_riscv_wb_arbiter: randomized and directed checks of the writeback arbiter against a queue model
module tb_riscv_wb_arbiter;
   localparam int XLEN  = 64;
   localparam int DEPTH = 2;

   typedef struct {
      logic [4:0]      a;
      logic [XLEN-1:0] d;
      bit              v;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   ent_t            mq[$];
   logic            exp_we = 1'b0;
   logic [4:0]      exp_addr = '0;
   logic [XLEN-1:0] exp_data = '0;
   bit              exp_known = 1'b1;
   logic [4:0]      wlog[$];

   riscv_wb_arbiter_if #(.XLEN(XLEN)) wb ();

   riscv_wb_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
      .i_riscv_wb_clk (clk),
      .i_riscv_rf_rst (rst),
      .wb             (wb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit mbusy(input logic [4:0] rs);
      bit b = 1'b0;
      foreach (mq[i]) if (mq[i].v && mq[i].a == rs) b = 1'b1;
      return b && rs != 5'd0;
   endfunction

   // Reference model: priority rules applied to a queue of pending divider results
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_known = 1'b1;
      end else begin
         bit pa, xfer, byp;
         ent_t e;
         pa   = wb.i_riscv_wb_pipe_regwrite && wb.i_riscv_wb_pipe_rdaddr != 5'd0;
         xfer = wb.i_riscv_wb_div_valid && mq.size() < DEPTH && wb.i_riscv_wb_div_rdaddr != 5'd0;
         byp  = 1'b0;
         if (pa) begin
            exp_we = 1'b1; exp_addr = wb.i_riscv_wb_pipe_rdaddr; exp_data = wb.i_riscv_wb_pipe_rddata; exp_known = 1'b1;
            foreach (mq[i]) if (mq[i].a == wb.i_riscv_wb_pipe_rdaddr) mq[i].v = 1'b0;
         end else if (mq.size() > 0) begin
            e = mq.pop_front();
            exp_we = e.v;
            if (e.v) begin exp_addr = e.a; exp_data = e.d; exp_known = 1'b1; end
            else exp_known = 1'b0;
         end else if (xfer) begin
            exp_we = 1'b1; exp_addr = wb.i_riscv_wb_div_rdaddr; exp_data = wb.i_riscv_wb_div_rddata; exp_known = 1'b1;
            byp = 1'b1;
         end else exp_we = 1'b0;
         if (xfer && !byp && !(pa && wb.i_riscv_wb_div_rdaddr == wb.i_riscv_wb_pipe_rdaddr)) begin
            e.a = wb.i_riscv_wb_div_rdaddr; e.d = wb.i_riscv_wb_div_rddata; e.v = 1'b1;
            mq.push_back(e);
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model, away from the clock edge
   always @(negedge clk) begin
      chk("div_ready", {63'd0, wb.o_riscv_wb_div_ready}, {63'd0, (mq.size() < DEPTH)});
      chk("rs1_busy", {63'd0, wb.o_riscv_wb_rs1_busy}, {63'd0, mbusy(wb.i_riscv_wb_chk_rs1addr)});
      chk("rs2_busy", {63'd0, wb.o_riscv_wb_rs2_busy}, {63'd0, mbusy(wb.i_riscv_wb_chk_rs2addr)});
      chk("regwrite", {63'd0, wb.o_riscv_wb_regwrite}, {63'd0, exp_we});
      if (exp_known) begin
         chk("rdaddr", {59'd0, wb.o_riscv_wb_rdaddr}, {59'd0, exp_addr});
         chk("rddata", wb.o_riscv_wb_rddata, exp_data);
      end
      if (wb.o_riscv_wb_regwrite) wlog.push_back(wb.o_riscv_wb_rdaddr);
   end

   // Drive one cycle of inputs; acc reports whether the divider offer was taken
   task automatic step(input logic pr, input logic [4:0] pa, input logic [XLEN-1:0] pd,
                       input logic dv, input logic [4:0] da, input logic [XLEN-1:0] dd, output logic acc);
      wb.i_riscv_wb_pipe_regwrite = pr;
      wb.i_riscv_wb_pipe_rdaddr   = pa;
      wb.i_riscv_wb_pipe_rddata   = pd;
      wb.i_riscv_wb_div_valid     = dv;
      wb.i_riscv_wb_div_rdaddr    = da;
      wb.i_riscv_wb_div_rddata    = dd;
      #1;
      acc = dv && wb.o_riscv_wb_div_ready;
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic acc;
      int   k, n;
      logic [4:0] exp_seq [7];
      wb.i_riscv_wb_chk_rs1addr = 5'd0;
      wb.i_riscv_wb_chk_rs2addr = 5'd0;
      step(0, 0, 0, 0, 0, 0, acc);
      #1;
      chk("lit_reset_we", {63'd0, wb.o_riscv_wb_regwrite}, 64'd0);
      chk("lit_reset_ready", {63'd0, wb.o_riscv_wb_div_ready}, 64'd1);
      step(0, 0, 0, 0, 0, 0, acc);
      rst = 1'b0;
      step(0, 0, 0, 0, 0, 0, acc);

      step(0, 0, 0, 1, 5'd5, 64'h1234, acc);
      chk("lit_bypass_we", {63'd0, wb.o_riscv_wb_regwrite}, 64'd1);
      chk("lit_bypass_addr", {59'd0, wb.o_riscv_wb_rdaddr}, 64'd5);
      chk("lit_bypass_data", wb.o_riscv_wb_rddata, 64'h1234);
      chk("lit_bypass_ready", {63'd0, wb.o_riscv_wb_div_ready}, 64'd1);

      wb.i_riscv_wb_chk_rs1addr = 5'd7;
      step(1, 5'd1, 64'h11, 1, 5'd7, 64'hA, acc);
      chk("lit_q_addr1", {59'd0, wb.o_riscv_wb_rdaddr}, 64'd1);
      chk("lit_q_busy7", {63'd0, wb.o_riscv_wb_rs1_busy}, 64'd1);
      step(1, 5'd2, 64'h22, 1, 5'd8, 64'hB, acc);
      chk("lit_q_addr2", {59'd0, wb.o_riscv_wb_rdaddr}, 64'd2);
      chk("lit_q_full_ready", {63'd0, wb.o_riscv_wb_div_ready}, 64'd0);
      step(1, 5'd3, 64'h33, 0, 0, 0, acc);
      chk("lit_q_addr3", {59'd0, wb.o_riscv_wb_rdaddr}, 64'd3);
      step(0, 0, 0, 0, 0, 0, acc);
      chk("lit_q_addr7", {59'd0, wb.o_riscv_wb_rdaddr}, 64'd7);
      chk("lit_q_data7", wb.o_riscv_wb_rddata, 64'hA);
      step(0, 0, 0, 0, 0, 0, acc);
      chk("lit_q_addr8", {59'd0, wb.o_riscv_wb_rdaddr}, 64'd8);
      chk("lit_q_data8", wb.o_riscv_wb_rddata, 64'hB);
      chk("lit_q_busy7_clear", {63'd0, wb.o_riscv_wb_rs1_busy}, 64'd0);

      wb.i_riscv_wb_chk_rs1addr = 5'd9;
      step(1, 5'd1, 64'h44, 1, 5'd9, 64'hDEAD, acc);
      chk("lit_waw_busy9", {63'd0, wb.o_riscv_wb_rs1_busy}, 64'd1);
      step(1, 5'd9, 64'hBEEF, 0, 0, 0, acc);
      chk("lit_waw_data", wb.o_riscv_wb_rddata, 64'hBEEF);
      chk("lit_waw_busy9_clear", {63'd0, wb.o_riscv_wb_rs1_busy}, 64'd0);
      step(0, 0, 0, 0, 0, 0, acc);
      chk("lit_waw_killed_we", {63'd0, wb.o_riscv_wb_regwrite}, 64'd0);

      repeat (2) begin
         step(1, 5'd0, 64'h55, 1, 5'd0, 64'h66, acc);
         chk("lit_x0_we", {63'd0, wb.o_riscv_wb_regwrite}, 64'd0);
         chk("lit_x0_ready", {63'd0, wb.o_riscv_wb_div_ready}, 64'd1);
      end

      step(0, 0, 0, 0, 0, 0, acc);
      wlog.delete();
      step(1, 5'd1, 64'h1, 1, 5'd10, 64'd100, acc);
      step(1, 5'd2, 64'h2, 1, 5'd11, 64'd101, acc);
      k = 2; n = 0;
      while (k < 5 && n < 50) begin
         step(0, 0, 0, 1, 5'(10 + k), 64'(100 + k), acc);
         if (acc) k++;
         n++;
      end
      if (k < 5) chk("full_accept_timeout", 64'(k), 64'd5);
      repeat (3) step(0, 0, 0, 0, 0, 0, acc);
      @(negedge clk);
      #1;
      exp_seq = '{5'd1, 5'd2, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
      chk("lit_full_count", 64'(wlog.size()), 64'd7);
      for (int i = 0; i < 7 && i < wlog.size(); i++) chk("lit_full_order", {59'd0, wlog[i]}, {59'd0, exp_seq[i]});
      @(posedge clk);
      #2;

      step(1, 5'd1, 64'h1, 1, 5'd20, 64'hC0, acc);
      step(1, 5'd2, 64'h2, 1, 5'd21, 64'hC1, acc);
      rst = 1'b1;
      wlog.delete();
      #1;
      chk("lit_rst_we", {63'd0, wb.o_riscv_wb_regwrite}, 64'd0);
      chk("lit_rst_ready", {63'd0, wb.o_riscv_wb_div_ready}, 64'd1);
      step(0, 0, 0, 0, 0, 0, acc);
      rst = 1'b0;
      wb.i_riscv_wb_chk_rs1addr = 5'd20;
      wb.i_riscv_wb_chk_rs2addr = 5'd21;
      repeat (4) step(0, 0, 0, 0, 0, 0, acc);
      chk("lit_rst_busy1", {63'd0, wb.o_riscv_wb_rs1_busy}, 64'd0);
      chk("lit_rst_busy2", {63'd0, wb.o_riscv_wb_rs2_busy}, 64'd0);
      chk("lit_rst_no_write", 64'(wlog.size()), 64'd0);

      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         wb.i_riscv_wb_chk_rs1addr = 5'($urandom_range(0, 7));
         wb.i_riscv_wb_chk_rs2addr = 5'($urandom_range(0, 7));
         step(($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), {$urandom, $urandom},
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom}, acc);
      end
      rst = 1'b0;
      step(0, 0, 0, 0, 0, 0, acc);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/riscv_wb_arbiter.md
Name: riscv_wb_arbiter

Overview:
- Writeback-stage arbiter that drives the single register-file write port (regwrite, rdaddr, rddata).
- Merges two sources:
  - the in-order pipeline writeback, which is never stalled and always wins;
  - results from the long-latency M-extension divider, accepted through a valid/ready handshake.
- Divider results that lose arbitration wait in a small FIFO.
- Decode uses the busy outputs to detect RAW hazards on queued destinations.

Parameters:
- XLEN, 64, data width of the register write.
- FIFO_DEPTH, 2, number of divider results that can be queued (power of 2, >=2).

Ports:
- i_riscv_wb_clk  input  1  clock; all state updates on posedge.
- i_riscv_rf_rst  input  1  reset, asynchronous, active-high.
- i_riscv_wb_pipe_regwrite  input  1  pipeline writeback request.
- i_riscv_wb_pipe_rdaddr  input  5  pipeline destination register.
- i_riscv_wb_pipe_rddata  input  XLEN  pipeline write data.
- i_riscv_wb_div_valid  input  1  divider result valid.
- i_riscv_wb_div_rdaddr  input  5  divider destination register.
- i_riscv_wb_div_rddata  input  XLEN  divider result.
- o_riscv_wb_div_ready  output  1  arbiter can accept a divider result.
- i_riscv_wb_chk_rs1addr  input  5  decode rs1 to check.
- i_riscv_wb_chk_rs2addr  input  5  decode rs2 to check.
- o_riscv_wb_rs1_busy  output  1  rs1 matches a valid queued entry.
- o_riscv_wb_rs2_busy  output  1  rs2 matches a valid queued entry.
- o_riscv_wb_regwrite  output  1  register-file write enable (registered).
- o_riscv_wb_rdaddr  output  5  register-file write address (registered).
- o_riscv_wb_rddata  output  XLEN  register-file write data (registered).

Behaviour:
- **Reset values.**
  - Reset asserted: o_riscv_wb_regwrite=0, rdaddr=0, rddata=0, FIFO count=0, all entry valid bits cleared.
  - Reset asserted mid-operation discards all queued results with no write.
- **Handshakes.**
  - Pipeline request is active only when pipe_regwrite=1 and pipe_rdaddr!=0.
  - div_ready = (count < FIFO_DEPTH); combinational from count only, so it is 1 out of reset.
  - A divider transfer occurs when div_valid && div_ready.
  - Divider transfers with div_rdaddr=0 are accepted and discarded.
- **Output register.** All outputs load on posedge, giving 1-cycle latency from the winning source. Priority each cycle:
  1. Pipeline request active: output = pipeline write.
  2. Else FIFO head valid: output = head, pop.
  3. Else FIFO head invalid (killed): pop with regwrite=0.
  4. Else FIFO empty and divider transfer: output = divider (bypass, no push).
  5. Else regwrite=0; rdaddr/rddata hold their previous values.
- **Push.** An accepted divider transfer pushes to the FIFO tail when it does not bypass (FIFO non-empty or pipeline active).
  - Simultaneous push and pop is allowed; count is unchanged.
  - Push while full is impossible (ready=0).
  - Pointers wrap modulo FIFO_DEPTH.
- **WAW kill.** A pipeline request to rd X clears the valid bit of every queued entry with rdaddr X, because the pipeline write is younger.
  - A divider transfer in the same cycle with rdaddr X is discarded rather than pushed.
- **Busy.** rsN_busy=1 iff chk_rsNaddr!=0 and some queued entry has valid=1 and rdaddr equal to it. Purely combinational.
- **Ordering.** Divider results retire in acceptance order; the FIFO never reorders.
- **No-drop rule.** Every accepted, non-killed, non-zero-rd divider result produces exactly one write.

Test Plan:
- **Reset.** Assert reset mid-stream with 2 queued entries, then release → regwrite=0, div_ready=1, busy=0, no write of queued data ever appears.
- **Bypass.** Idle pipeline, div_valid with rd=5, data=0x1234 → next posedge regwrite=1, rdaddr=5, rddata=0x1234; FIFO stays empty.
- **Queue and drain.** Pipeline writes rd=1,2,3 on consecutive cycles while divider presents rd=7 then rd=8 (0xA, 0xB) → writes appear in order 1,2,3,7,8. div_ready drops to 0 once 2 are queued. rs1_busy=1 for chk rs1=7 while queued.
- **WAW kill.** Queue rd=9 (0xDEAD) behind a pipeline write, then pipeline writes rd=9 (0xBEEF) → only 0xBEEF is written to x9. Killed slot pops with regwrite=0; rs busy for 9 clears the cycle after the kill.
- **x0 handling.** Pipeline writes rd=0 and divider sends rd=0 → regwrite never asserts; div_ready stays 1.
- **Full FIFO with simultaneous pop.** Hold pipeline idle with 2 entries queued and div_valid high → one pop per cycle, one accept per freed slot, 5 divider results retire in order with no loss.
